// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, oversampling constants and default
// frame-format parameters, also used by the future transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_rx_state_t;

   // s_tick periods per bit, and the s count at which the start bit is re-checked.
   localparam int unsigned OVERSAMPLE  = 16;
   localparam int unsigned MID_SAMPLE  = 7;

   localparam int unsigned DEF_DBIT    = 8;
   localparam int unsigned DEF_SB_TICK = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk_i   : destination clock
//   rst_i   : synchronous active-high reset; both flops load RESET_VAL
//   d_i     : asynchronous input
//   q_o     : synchronized output (2 clk latency)
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: deserializes one start / DBIT data (LSB first) / stop frame from rx,
// oversampled by the 16x-baud s_tick enable.
//   clk          : system clock
//   reset        : synchronous active-high reset
//   rx           : asynchronous serial input, idle high
//   s_tick       : 16x-baud enable pulse, one clk wide
//   rx_done_tick : one-clk strobe, dout/frame_err updated
//   dout         : last received byte, zero-extended above DBIT-1
//   frame_err    : stop bit of the last completed frame sampled low
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DBIT    = DEF_DBIT,
   parameter int unsigned SB_TICK = DEF_SB_TICK
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       s_tick,
   output logic       rx_done_tick,
   output logic [7:0] dout,
   output logic       frame_err
);

   logic rx_s;

   uart_rx_state_t  state_q, state_d;
   logic [4:0]      s_q, s_d;
   logic [2:0]      n_q, n_d;
   logic [DBIT-1:0] shift_q, shift_d;
   logic [7:0]      dout_q, dout_d;
   logic            ferr_q, ferr_d;
   logic            done_q, done_d;

   // Preset high so a reset never looks like a start edge.
   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         ferr_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         ferr_q  <= ferr_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      ferr_d  = ferr_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Reacts on any clk; a coincident s_tick is not counted.
            if (!rx_s) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_q == 5'(MID_SAMPLE)) begin
                  if (!rx_s) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     // Line back high at mid start bit: glitch, no frame.
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == 5'(OVERSAMPLE - 1)) begin
                  s_d     = '0;
                  shift_d = {rx_s, shift_q[DBIT-1:1]};
                  if (n_q == 3'(DBIT - 1)) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + 3'd1;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_q == 5'(SB_TICK - 1)) begin
                  state_d = IDLE;
                  dout_d  = 8'(shift_q);
                  ferr_d  = ~rx_s;
                  done_d  = 1'b1;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_done_tick = done_q;
   assign dout         = dout_q;
   assign frame_err    = ferr_q;

endmodule
